// File: rtl/pipe_elastic_stage_pkg.sv
// Shared types and defaults for the elastic pipeline stage.
// Holds the default depth / counter width, the ID->EX payload layout and the
// pointer-width helper used by both the stage and its storage array.
package pipe_elastic_stage_pkg;

  // ID->EX payload bundle; all-zero value is the NOP bubble.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } id_ex_payload_t;

  localparam int unsigned PIPE_DEPTH_DEF  = 2;
  localparam int unsigned PIPE_CNT_W_DEF  = 16;
  localparam int unsigned ID_EX_PAYLOAD_W = $bits(id_ex_payload_t);

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_elastic_mem.sv
// Storage array for pipe_elastic_stage: DEPTH x DATA_W, one synchronous write
// port, asynchronous read. Contents are deliberately not reset.
// Ports:
//   clk      in   clock, rising edge
//   we       in   write enable
//   wr_addr  in   write slot
//   wr_data  in   write payload
//   rd_addr  in   read slot
//   rd_data  out  payload at rd_addr (combinational)
module pipe_elastic_mem
  import pipe_elastic_stage_pkg::*;
#(
  parameter int unsigned DATA_W = ID_EX_PAYLOAD_W,
  parameter int unsigned DEPTH  = PIPE_DEPTH_DEF,
  localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: circular buffer of DEPTH payloads with valid/ready
// handshakes on both sides, flush, and all-zero NOP output when empty.
// Optional perf counters are built when PIPE_ELASTIC_PERF_EN is defined;
// otherwise stall_cnt / bubble_cnt are tied to zero (same port list).
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             drop every held entry on the next edge
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and head payload
//   level             entries currently held (registered)
//   stall_cnt         cycles with out_valid && !out_ready (saturating)
//   bubble_cnt        cycles with !out_valid (saturating)
module pipe_elastic_stage
  import pipe_elastic_stage_pkg::*;
#(
  parameter int unsigned DATA_W = ID_EX_PAYLOAD_W,
  parameter int unsigned DEPTH  = PIPE_DEPTH_DEF,
  parameter int unsigned CNT_W  = PIPE_CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [DATA_W-1:0] rd_data;
  logic              push;
  logic              pop;

  // Handshake depends only on registered state, rst and flush (no out_ready path).
  assign in_ready  = !rst && !flush && (count != LVL_W'(DEPTH));
  assign out_valid = !rst && !flush && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? rd_data : '0;
  assign level     = count;

  pipe_elastic_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_ELASTIC_PERF_EN
  // Saturating perf counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && (bubble_cnt != '1))             bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
